// File: rtl/axi4_lite_write_arbiter.sv
// Round-robin arbiter sharing one memory write port between the AXI4-Lite write path (port 0)
// and the core writeback path (port 1), with address range check and a bounded memory handshake.
module axi4_lite_write_arbiter #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 64'h0000_1000,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_req_0,
    input  logic [ADDR_WIDTH-1:0] i_addr_0,
    input  logic [DATA_WIDTH-1:0] i_data_0,
    input  logic                  i_req_1,
    input  logic [ADDR_WIDTH-1:0] i_addr_1,
    input  logic [DATA_WIDTH-1:0] i_data_1,
    output logic                  o_done_0,
    output logic                  o_ok_0,
    output logic                  o_done_1,
    output logic                  o_ok_1,
    output logic                  o_mem_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                  state_reg;
    logic                    last_grant_reg;
    logic                    grant_reg;
    logic [7:0]              cnt_reg;
    logic [1:0]              done_reg;
    logic [1:0]              ok_reg;

    logic                    grant_next;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    req_granted;

    // On a tie the port that was not served last wins, so neither side can starve.
    assign grant_next  = (i_req_0 && i_req_1) ? ~last_grant_reg : i_req_1;
    assign sel_addr    = grant_next ? i_addr_1 : i_addr_0;
    assign sel_data    = grant_next ? i_data_1 : i_data_0;
    assign req_granted = grant_reg ? i_req_1 : i_req_0;

    assign o_done_0 = done_reg[0];
    assign o_done_1 = done_reg[1];
    assign o_ok_0   = ok_reg[0];
    assign o_ok_1   = ok_reg[1];

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            cnt_reg        <= '0;
            done_reg       <= '0;
            ok_reg         <= '0;
            o_mem_valid    <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_data     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_req_0 || i_req_1) begin
                        grant_reg  <= grant_next;
                        o_mem_addr <= sel_addr;
                        o_mem_data <= sel_data;
                        if (sel_addr < ADDR_LIMIT) begin
                            state_reg   <= ACCESS;
                            o_mem_valid <= 1'b1;
                            cnt_reg     <= '0;
                        end else begin
                            // Out-of-range: report failure without touching memory.
                            state_reg            <= DONE;
                            done_reg[grant_next] <= 1'b1;
                            ok_reg[grant_next]   <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (i_mem_ready) begin
                        state_reg           <= DONE;
                        o_mem_valid         <= 1'b0;
                        done_reg[grant_reg] <= 1'b1;
                        ok_reg[grant_reg]   <= ~i_mem_err;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg           <= DONE;
                        o_mem_valid         <= 1'b0;
                        done_reg[grant_reg] <= 1'b1;
                        ok_reg[grant_reg]   <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    if (!req_granted) begin
                        state_reg      <= IDLE;
                        done_reg       <= '0;
                        ok_reg         <= '0;
                        last_grant_reg <= grant_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// Directed bench for axi4_lite_write_arbiter: expected transactions are queued when requests
// are raised and compared against the completion seen at the DUT outputs.
module tb_axi4_lite_write_arbiter;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        req_0 = 1'b0, req_1 = 1'b0;
    logic [63:0] addr_0 = '0, addr_1 = '0;
    logic [31:0] data_0 = '0, data_1 = '0;
    logic        done_0, ok_0, done_1, ok_1;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready = 1'b0;
    logic        mem_err = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int          port;
        logic [63:0] addr;
        logic [31:0] data;
        logic        ok;
        int          vcycles;
    } tx_t;

    tx_t sb[$];

    always #5 clk = ~clk;

    axi4_lite_write_arbiter dut (
        .clk         (clk),
        .arstn       (arstn),
        .i_req_0     (req_0),
        .i_addr_0    (addr_0),
        .i_data_0    (data_0),
        .i_req_1     (req_1),
        .i_addr_1    (addr_1),
        .i_data_1    (data_1),
        .o_done_0    (done_0),
        .o_ok_0      (ok_0),
        .o_done_1    (done_1),
        .o_ok_1      (ok_1),
        .o_mem_valid (mem_valid),
        .o_mem_addr  (mem_addr),
        .o_mem_data  (mem_data),
        .i_mem_ready (mem_ready),
        .i_mem_err   (mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic req_on(input int p, input logic [63:0] a, input logic [31:0] d);
        if (p == 0) begin req_0 = 1'b1; addr_0 = a; data_0 = d; end
        else        begin req_1 = 1'b1; addr_1 = a; data_1 = d; end
    endtask

    task automatic expect_tx(input int p, input logic [63:0] a, input logic [31:0] d,
                             input logic ok, input int vc);
        tx_t t;
        t.port = p; t.addr = a; t.data = d; t.ok = ok; t.vcycles = vc;
        sb.push_back(t);
    endtask

    // Serve one transaction: memory answers d cycles after valid rises (d<0: never).
    task automatic serve(input string name, input int d, input logic err);
        tx_t         e;
        int          vc = 0;
        int          fv = 0;
        int          p;
        logic [63:0] ca = '0;
        logic [31:0] cd = '0;
        logic        stable = 1'b1;
        bit          got = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (done_0 || done_1) begin got = 1'b1; break; end
            if (mem_valid) begin
                vc++;
                if (vc == 1) begin fv = i; ca = mem_addr; cd = mem_data; end
                else if (mem_addr !== ca || mem_data !== cd) stable = 1'b0;
            end
            if (mem_valid && (vc - 1) == d) begin mem_ready = 1'b1; mem_err = err; end
            else begin mem_ready = 1'b0; mem_err = 1'b0; end
        end
        mem_ready = 1'b0;
        mem_err = 1'b0;
        if (!got || sb.size() == 0) begin
            chk({name, "_done_seen"}, 64'(got), 64'(sb.size() != 0));
            req_0 = 1'b0; req_1 = 1'b0;
            repeat (3) @(negedge clk);
            return;
        end
        e = sb.pop_front();
        p = done_1 ? 1 : 0;
        chk({name, "_port"}, 64'(p), 64'(e.port));
        chk({name, "_ok"}, 64'(p == 1 ? ok_1 : ok_0), 64'(e.ok));
        chk({name, "_other_done"}, 64'(p == 1 ? done_0 : done_1), 64'd0);
        chk({name, "_valid_low"}, 64'(mem_valid), 64'd0);
        chk({name, "_valid_cycles"}, 64'(vc), 64'(e.vcycles));
        if (e.vcycles > 0) begin
            chk({name, "_addr"}, ca, e.addr);
            chk({name, "_data"}, 64'(cd), 64'(e.data));
            chk({name, "_stable"}, 64'(stable), 64'd1);
            chk({name, "_valid_latency"}, 64'(fv), 64'd1);
        end
        @(negedge clk);
        chk({name, "_done_held"}, 64'(p == 1 ? done_1 : done_0), 64'd1);
        if (p == 1) req_1 = 1'b0; else req_0 = 1'b0;
        @(negedge clk);
        chk({name, "_done_clear"}, {60'd0, done_0, done_1, ok_0, ok_1}, 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_outputs", {60'd0, done_0, done_1, ok_0, ok_1}, 64'd0);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        // Tie from reset: port 0 first, then port 1 after one idle bubble
        req_on(0, 64'h20, 32'h1111_1111);
        req_on(1, 64'h30, 32'h2222_2222);
        expect_tx(0, 64'h20, 32'h1111_1111, 1'b1, 1);
        expect_tx(1, 64'h30, 32'h2222_2222, 1'b1, 1);
        serve("tie1_a", 0, 1'b0);
        serve("tie1_b", 0, 1'b0);

        // Single port-0 write, memory ready 2 cycles after valid
        req_on(0, 64'h10, 32'hDEAD_BEEF);
        expect_tx(0, 64'h10, 32'hDEAD_BEEF, 1'b1, 3);
        serve("single0", 2, 1'b0);

        // Second tie: port 0 served last, so port 1 wins
        req_on(0, 64'h24, 32'h3333_3333);
        req_on(1, 64'h34, 32'h4444_4444);
        expect_tx(1, 64'h34, 32'h4444_4444, 1'b1, 1);
        expect_tx(0, 64'h24, 32'h3333_3333, 1'b1, 1);
        serve("tie2_a", 0, 1'b0);
        serve("tie2_b", 0, 1'b0);

        // Out-of-range address: no memory access, done after one cycle with ok=0
        req_on(1, 64'h1000, 32'h5555_5555);
        expect_tx(1, 64'h1000, 32'h5555_5555, 1'b0, 0);
        serve("oor1", -1, 1'b0);

        // Last in-range address with a slow memory
        req_on(1, 64'hFFF, 32'h6666_6666);
        expect_tx(1, 64'hFFF, 32'h6666_6666, 1'b1, 5);
        serve("edge1", 4, 1'b0);

        // Timeout: memory never ready
        req_on(0, 64'h40, 32'h7777_7777);
        expect_tx(0, 64'h40, 32'h7777_7777, 1'b0, 16);
        serve("timeout0", -1, 1'b0);

        // Memory error
        req_on(1, 64'h50, 32'h8888_8888);
        expect_tx(1, 64'h50, 32'h8888_8888, 1'b0, 2);
        serve("memerr1", 1, 1'b1);

        // Ready pulses while idle are ignored
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        chk("stray_ready_valid", 64'(mem_valid), 64'd0);
        chk("stray_ready_done", {62'd0, done_0, done_1}, 64'd0);

        // Reset in the middle of an access
        req_on(0, 64'h60, 32'h9999_9999);
        @(negedge clk);
        chk("mid_valid_before_rst", 64'(mem_valid), 64'd1);
        #2 arstn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(mem_valid), 64'd0);
        chk("mid_rst_addr", mem_addr, 64'd0);
        chk("mid_rst_done", {60'd0, done_0, done_1, ok_0, ok_1}, 64'd0);
        @(negedge clk);
        req_0 = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        // Tie after reset: port 0 wins again
        req_on(0, 64'h70, 32'hAAAA_AAAA);
        req_on(1, 64'h80, 32'hBBBB_BBBB);
        expect_tx(0, 64'h70, 32'hAAAA_AAAA, 1'b1, 1);
        expect_tx(1, 64'h80, 32'hBBBB_BBBB, 1'b1, 1);
        serve("tie3_a", 0, 1'b0);
        serve("tie3_b", 0, 1'b0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi4_lite_write_arbiter.md
# axi4_lite_write_arbiter

Two-port write arbiter that shares one memory write port between two write masters: port 0 is the AXI4-Lite slave write path (its `o_addr`/`o_data`/`o_write_en` outputs), port 1 is the core-side writeback path. It grants one requester at a time round-robin, range-checks the address, drives a valid/ready memory write handshake with a timeout, and returns per-port completion and success flags. The AXI write slave consumes these flags as `i_successful_access`/`i_successful_write`.

## Interface
- `ADDR_WIDTH`, 64, address width of both ports and the memory port.
- `DATA_WIDTH`, 32, data width.
- `ADDR_LIMIT`, 64'h0000_1000, first illegal address; addresses `>= ADDR_LIMIT` are rejected without a memory access.
- `TIMEOUT`, 16, maximum cycles to wait for `i_mem_ready`; range 1..255.
- `clk` in 1: clock, rising edge.
- `arstn` in 1: asynchronous, active-low reset.
- `i_req_0`, `i_req_1` in 1 each: write request level, held until done is seen.
- `i_addr_0`, `i_addr_1` in ADDR_WIDTH each: write address, stable while req is high.
- `i_data_0`, `i_data_1` in DATA_WIDTH each: write data, stable while req is high.
- `o_done_0`, `o_done_1` out 1 each: access finished; held until the matching req falls.
- `o_ok_0`, `o_ok_1` out 1 each: write succeeded; valid while done is high, 0 otherwise.
- `o_mem_valid` out 1: memory write request.
- `o_mem_addr` out ADDR_WIDTH: latched address.
- `o_mem_data` out DATA_WIDTH: latched data.
- `i_mem_ready` in 1: memory accepted and completed the write.
- `i_mem_err` in 1: sampled with `i_mem_ready`; 1 means the write failed.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high, choose a grant `g`.
  - Only one requester: grant it.
  - Both requesting: grant the port that is not `last_grant`.
  - Latch `i_addr_g`/`i_data_g` into `o_mem_addr`/`o_mem_data` and record `g`.
  - Address `< ADDR_LIMIT`: go to ACCESS with `o_mem_valid`=1 and timeout counter=0.
  - Otherwise: go to DONE with `ok`=0 and no memory access.
- ACCESS: `o_mem_valid` stays 1.
  - `i_mem_ready`=1: go to DONE with `ok = ~i_mem_err`, and `o_mem_valid`=0 from the next cycle.
  - Otherwise the counter increments. When it reaches `TIMEOUT-1` without ready, go to DONE with `ok`=0 and `o_mem_valid`=0.
- DONE: `o_done_g`=1 and `o_ok_g`=ok; the non-granted port's outputs stay 0.
  - When `i_req_g`=0: clear done/ok, set `last_grant=g`, go to IDLE.
- A requester that drops req while in ACCESS is not aborted. The memory access completes, DONE is entered, and DONE exits on the next cycle because req is already low.
- The non-granted requester is never starved. After any completion, a pending request on the other port wins the next arbitration.

## Timing
- Reset values: state=IDLE, `last_grant`=1 (port 0 wins the first tie), all `o_done_*`/`o_ok_*`/`o_mem_valid`=0, `o_mem_addr`/`o_mem_data`=0, counter=0.
- Reset is asynchronous. Asserting it mid-ACCESS drops `o_mem_valid` immediately; no completion is reported.
- All outputs are registered. Port and memory signals are sampled on the rising edge.
- Latency from req rising to `o_mem_valid`: 1 cycle.
- Latency from `i_mem_ready` to `o_done_g`: 1 cycle, with `o_mem_valid` falling in the same cycle.
- Minimum in-range transaction with a 0-wait memory: req@T, valid@T+1, ready@T+1, done@T+2.
- Out-of-range transaction: done@T+1 with ok=0.
- Timeout: `o_mem_valid` is high for exactly `TIMEOUT` cycles, then done rises on the next edge.
- After req falls in DONE: done clears and the FSM reaches IDLE on the same edge. A new grant is possible on the following edge, so each transaction has one IDLE bubble.
- Memory contract: `i_mem_ready` is only meaningful while `o_mem_valid`=1 and is ignored otherwise. `o_mem_addr`/`o_mem_data` are stable throughout ACCESS.

## Test plan
- Single write, port 0: addr=0x10, data=0xDEADBEEF, memory ready 2 cycles after valid, err=0.
  - Required: `o_mem_addr`=0x10 and `o_mem_data`=0xDEADBEEF for 3 valid cycles, then `o_done_0`=1, `o_ok_0`=1 held until `i_req_0` falls.
- Simultaneous requests from reset: port 0 addr=0x20, port 1 addr=0x30, ready immediate.
  - Required: port 0 is served first. Port 1's `o_mem_valid` rises 1 cycle after `i_req_0` falls.
  - Second tie: port 1 wins.
- Out-of-range write: port 1 addr=0x1000 with the default limit.
  - Required: `o_mem_valid` never rises. `o_done_1`=1, `o_ok_1`=0 one cycle after req.
- Timeout: `i_mem_ready` held 0, `TIMEOUT`=16.
  - Required: valid high for exactly 16 cycles, then done=1 and ok=0.
- Memory error: ready=1 with `i_mem_err`=1.
  - Required: done=1, ok=0.
  - Also: ready pulses while valid=0 are ignored.
- Reset mid-ACCESS: assert `arstn`=0 while valid=1.
  - Required: all outputs are 0 asynchronously. After release, a tie is again won by port 0.
